// File: rtl/cart_pkg.sv
// Shared definitions for the cart motion logic: operation codes, game FSM
// state codes and default field geometry.
package cart_pkg;

  typedef enum logic [2:0] {
    OP_NIL   = 3'd0,
    OP_UP    = 3'd1,
    OP_DOWN  = 3'd2,
    OP_LEFT  = 3'd3,
    OP_RIGHT = 3'd4
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTING   = 3'd1,
    ST_SYNCING   = 3'd2,
    ST_COUNTDOWN = 3'd3,
    ST_RACING    = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_FINISH    = 3'd6
  } game_state_t;

  localparam int FIELD_W_DEF   = 640;
  localparam int FIELD_H_DEF   = 480;
  localparam int CART_SIZE_DEF = 32;

  // Codes 5..7 are unused by the encoder and behave like NIL.
  function automatic logic op_is_move(input logic [2:0] op);
    return (op != OP_NIL) && (op <= OP_RIGHT);
  endfunction

endpackage

// File: rtl/cart_step_calc.sv
// Combinational next-position calculator for one cart: applies one step of
// STEP (or 2*STEP with boost) in the op direction, saturating to the field.
module cart_step_calc
  import cart_pkg::*;
#(
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int FIELD_W   = FIELD_W_DEF,
  parameter int FIELD_H   = FIELD_H_DEF,
  parameter int CART_SIZE = CART_SIZE_DEF,
  parameter int STEP      = 2
) (
  input  logic [2:0]     op,
  input  logic           boost,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y
);

  localparam logic [X_W:0] X_MAX   = (X_W+1)'(FIELD_W - CART_SIZE);
  localparam logic [Y_W:0] Y_MAX   = (Y_W+1)'(FIELD_H - CART_SIZE);
  localparam logic [X_W:0] X_STEP  = (X_W+1)'(STEP);
  localparam logic [X_W:0] X_STEP2 = (X_W+1)'(2 * STEP);
  localparam logic [Y_W:0] Y_STEP  = (Y_W+1)'(STEP);
  localparam logic [Y_W:0] Y_STEP2 = (Y_W+1)'(2 * STEP);

  logic [X_W:0] step_x, sum_x, dif_x;
  logic [Y_W:0] step_y, sum_y, dif_y;

  // One extra bit catches both underflow (top bit set) and overshoot past the edge.
  always_comb begin
    step_x = boost ? X_STEP2 : X_STEP;
    step_y = boost ? Y_STEP2 : Y_STEP;
    sum_x  = {1'b0, x} + step_x;
    dif_x  = {1'b0, x} - step_x;
    sum_y  = {1'b0, y} + step_y;
    dif_y  = {1'b0, y} - step_y;
    next_x = x;
    next_y = y;
    case (op)
      OP_UP:    next_y = dif_y[Y_W] ? '0 : dif_y[Y_W-1:0];
      OP_DOWN:  next_y = (sum_y > Y_MAX) ? Y_MAX[Y_W-1:0] : sum_y[Y_W-1:0];
      OP_LEFT:  next_x = dif_x[X_W] ? '0 : dif_x[X_W-1:0];
      OP_RIGHT: next_x = (sum_x > X_MAX) ? X_MAX[X_W-1:0] : sum_x[X_W-1:0];
      default:  ;
    endcase
  end

endmodule

// File: rtl/cart_motion_decoder.sv
// Cart motion decoder: latches per-cart direction/boost requests while racing
// and applies them as saturated position steps once per movement tick.
// Optional build macro CART_COLLISION_EN blocks a tick whose resulting cart
// boxes would overlap and reports it on collide_pulse.
module cart_motion_decoder
  import cart_pkg::*;
#(
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int FIELD_W   = FIELD_W_DEF,
  parameter int FIELD_H   = FIELD_H_DEF,
  parameter int CART_SIZE = CART_SIZE_DEF,
  parameter int STEP_DIV  = 1_000_000,
  parameter int STEP      = 2,
  parameter int P1_X0     = 160,
  parameter int P1_Y0     = 400,
  parameter int P2_X0     = 448,
  parameter int P2_Y0     = 400
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     state,
  input  logic [2:0]     p1_operation_code,
  input  logic           p1_boost,
  input  logic [2:0]     p2_operation_code,
  input  logic           p2_boost,
  output logic [X_W-1:0] p1_x,
  output logic [Y_W-1:0] p1_y,
  output logic [X_W-1:0] p2_x,
  output logic [Y_W-1:0] p2_y,
  output logic [2:0]     p1_dir,
  output logic [2:0]     p2_dir,
  output logic           move_pulse,
  output logic           collide_pulse
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             move_pulse_reg, collide_pulse_reg;
  logic             racing, paused, reload, tick, collide;

  logic [2:0]     op_in  [2];
  logic           boost_in [2];
  logic [X_W-1:0] pos_x  [2];
  logic [Y_W-1:0] pos_y  [2];
  logic [2:0]     dir    [2];
  logic [X_W-1:0] next_x [2];
  logic [Y_W-1:0] next_y [2];

  assign op_in[0]    = p1_operation_code;
  assign op_in[1]    = p2_operation_code;
  assign boost_in[0] = p1_boost;
  assign boost_in[1] = p2_boost;

  assign racing = (state == ST_RACING);
  assign paused = (state == ST_PAUSE);
  assign reload = (state == ST_IDLE) || (state == ST_SETTING);
  // State is sampled on the tick edge itself, so leaving RACING suppresses it.
  assign tick   = racing && (cnt_reg == CNT_LAST);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cart
      localparam logic [X_W-1:0] X0 = X_W'(gi == 0 ? P1_X0 : P2_X0);
      localparam logic [Y_W-1:0] Y0 = Y_W'(gi == 0 ? P1_Y0 : P2_Y0);

      logic [2:0]     pend_op_reg;
      logic           pend_boost_reg;
      logic [X_W-1:0] x_reg;
      logic [Y_W-1:0] y_reg;
      logic [2:0]     dir_reg;
      logic [2:0]     eff_op;
      logic           eff_boost;

      // The live input takes priority so a request on the tick edge is applied.
      assign eff_op    = op_is_move(op_in[gi]) ? op_in[gi] : pend_op_reg;
      assign eff_boost = pend_boost_reg | boost_in[gi];

      cart_step_calc #(
        .X_W(X_W), .Y_W(Y_W), .FIELD_W(FIELD_W), .FIELD_H(FIELD_H),
        .CART_SIZE(CART_SIZE), .STEP(STEP)
      ) u_step (
        .op(eff_op), .boost(eff_boost), .x(x_reg), .y(y_reg),
        .next_x(next_x[gi]), .next_y(next_y[gi])
      );

      // Pending request latch: accumulate while racing, hold in PAUSE/FINISH.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_op_reg    <= OP_NIL;
          pend_boost_reg <= 1'b0;
        end else if (racing && !tick) begin
          pend_op_reg    <= eff_op;
          pend_boost_reg <= eff_boost;
        end else if (!(paused || state == ST_FINISH)) begin
          pend_op_reg    <= OP_NIL;
          pend_boost_reg <= 1'b0;
        end
      end

      // Position and facing: reload at setup, step on tick unless blocked.
      always_ff @(posedge clk or posedge rst) begin
        if (rst || reload) begin
          x_reg   <= X0;
          y_reg   <= Y0;
          dir_reg <= OP_UP;
        end else if (tick) begin
          if (!collide) begin
            x_reg <= next_x[gi];
            y_reg <= next_y[gi];
          end
          if (op_is_move(eff_op)) dir_reg <= eff_op;
        end
      end

      assign pos_x[gi] = x_reg;
      assign pos_y[gi] = y_reg;
      assign dir[gi]   = dir_reg;
    end
  endgenerate

`ifdef CART_COLLISION_EN
  localparam logic [X_W:0] CS_X = (X_W+1)'(CART_SIZE);
  localparam logic [Y_W:0] CS_Y = (Y_W+1)'(CART_SIZE);
  logic [X_W:0] ax, bx;
  logic [Y_W:0] ay, by;
  assign ax = {1'b0, next_x[0]};
  assign bx = {1'b0, next_x[1]};
  assign ay = {1'b0, next_y[0]};
  assign by = {1'b0, next_y[1]};
  // Strict compares: boxes that only touch edges do not overlap.
  assign collide = (ax < bx + CS_X) && (bx < ax + CS_X) &&
                   (ay < by + CS_Y) && (by < ay + CS_Y);
`else
  assign collide = 1'b0;
`endif

  // Movement tick counter: runs in RACING, frozen in PAUSE, cleared otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt_reg <= '0;
    else if (tick)   cnt_reg <= '0;
    else if (racing) cnt_reg <= cnt_reg + CNT_W'(1);
    else if (!paused) cnt_reg <= '0;
  end

  // Status pulses, registered alongside the position update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      move_pulse_reg    <= 1'b0;
      collide_pulse_reg <= 1'b0;
    end else begin
      move_pulse_reg    <= tick;
      collide_pulse_reg <= tick && collide;
    end
  end

  assign p1_x          = pos_x[0];
  assign p1_y          = pos_y[0];
  assign p2_x          = pos_x[1];
  assign p2_y          = pos_y[1];
  assign p1_dir        = dir[0];
  assign p2_dir        = dir[1];
  assign move_pulse    = move_pulse_reg;
  assign collide_pulse = collide_pulse_reg;

endmodule

// File: tb/tb_cart_motion_decoder.sv
// Testbench for cart_motion_decoder (STEP_DIV=4, STEP=2) with a behavioural
// model of the cart game rules. Honours CART_COLLISION_EN when defined.
module tb_cart_motion_decoder;

  localparam int SD    = 4;
  localparam int ST    = 2;
  localparam int CS    = 32;
  localparam int XMAX  = 640 - CS;
  localparam int YMAX  = 480 - CS;
  localparam int X0[2] = '{160, 448};
  localparam int Y0[2] = '{400, 400};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state, p1op, p2op;
  logic       p1b, p2b;
  logic [9:0] p1_x, p1_y, p2_x, p2_y;
  logic [2:0] p1_dir, p2_dir;
  logic       move_pulse, collide_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int mx[2], my[2], mdir[2], mpo[2], mpb[2];
  int mcnt, mmove, mcol;

  always #5 clk = ~clk;

  cart_motion_decoder #(.STEP_DIV(SD), .STEP(ST)) dut (
    .clk(clk), .rst(rst), .state(state),
    .p1_operation_code(p1op), .p1_boost(p1b),
    .p2_operation_code(p2op), .p2_boost(p2b),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_dir(p1_dir), .p2_dir(p2_dir),
    .move_pulse(move_pulse), .collide_pulse(collide_pulse)
  );

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(string tag, logic [31:0] got, int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("p1_x", 32'(p1_x), mx[0]);
    chk("p1_y", 32'(p1_y), my[0]);
    chk("p2_x", 32'(p2_x), mx[1]);
    chk("p2_y", 32'(p2_y), my[1]);
    chk("p1_dir", 32'(p1_dir), mdir[0]);
    chk("p2_dir", 32'(p2_dir), mdir[1]);
    chk("move_pulse", 32'(move_pulse), mmove);
    chk("collide_pulse", 32'(collide_pulse), mcol);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mx[c] = X0[c]; my[c] = Y0[c]; mdir[c] = 1; mpo[c] = 0; mpb[c] = 0;
    end
    mcnt = 0; mmove = 0; mcol = 0;
  endtask

  // Game rules applied to one clock edge, from the inputs present before it.
  task automatic model_edge();
    int op_i[2], b_i[2], eo[2], eb[2], tx[2], ty[2];
    int s, st, overlap, blocked;
    op_i[0] = int'(p1op); op_i[1] = int'(p2op);
    b_i[0]  = int'(p1b);  b_i[1]  = int'(p2b);
    st = int'(state);
    mmove = 0; mcol = 0;
    if (st == 4) begin
      for (int c = 0; c < 2; c++) begin
        eo[c] = (op_i[c] >= 1 && op_i[c] <= 4) ? op_i[c] : mpo[c];
        eb[c] = mpb[c] | b_i[c];
      end
      if (mcnt == SD - 1) begin
        for (int c = 0; c < 2; c++) begin
          s = eb[c] ? 2 * ST : ST;
          tx[c] = mx[c]; ty[c] = my[c];
          if (eo[c] == 1) ty[c] = clampi(my[c] - s, 0, YMAX);
          if (eo[c] == 2) ty[c] = clampi(my[c] + s, 0, YMAX);
          if (eo[c] == 3) tx[c] = clampi(mx[c] - s, 0, XMAX);
          if (eo[c] == 4) tx[c] = clampi(mx[c] + s, 0, XMAX);
        end
        overlap = (tx[0] < tx[1] + CS && tx[1] < tx[0] + CS &&
                   ty[0] < ty[1] + CS && ty[1] < ty[0] + CS) ? 1 : 0;
`ifdef CART_COLLISION_EN
        blocked = overlap;
`else
        blocked = 0;
`endif
        for (int c = 0; c < 2; c++) begin
          if (blocked == 0) begin mx[c] = tx[c]; my[c] = ty[c]; end
          if (eo[c] != 0) mdir[c] = eo[c];
          mpo[c] = 0; mpb[c] = 0;
        end
        mcnt = 0; mmove = 1; mcol = blocked;
      end else begin
        mcnt++;
        for (int c = 0; c < 2; c++) begin mpo[c] = eo[c]; mpb[c] = eb[c]; end
      end
    end else begin
      if (st != 5) mcnt = 0;
      for (int c = 0; c < 2; c++) begin
        if (st <= 1) begin mx[c] = X0[c]; my[c] = Y0[c]; mdir[c] = 1; end
        if (st != 5 && st != 6) begin mpo[c] = 0; mpb[c] = 0; end
      end
    end
  endtask

  task automatic drive(int st, int o1, int b1, int o2, int b2);
    state = 3'(st); p1op = 3'(o1); p1b = b1[0]; p2op = 3'(o2); p2b = b2[0];
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One full movement period: request on first cycle, NIL for the rest.
  task automatic tick_with(int o1, int b1, int o2, int b2);
    drive(4, o1, b1, o2, b2);
    cycle();
    for (int i = 0; i < SD - 1; i++) begin
      drive(4, 0, 0, 0, 0);
      cycle();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // Single UP request, applied at the first tick
    tick_with(1, 0, 0, 0);
    chk("up_y", 32'(p1_y), 398);
    chk("up_dir", 32'(p1_dir), 1);
    chk("up_pulse", 32'(move_pulse), 1);
    drive(4, 0, 0, 0, 0);
    cycle();
    chk("pulse_one_cycle", 32'(move_pulse), 0);

    // RIGHT+boost pulse, then a tick with nothing pending
    drive(1, 0, 0, 0, 0); cycle();
    tick_with(4, 1, 0, 0);
    chk("boost_x", 32'(p1_x), 164);
    tick_with(0, 0, 0, 0);
    chk("cleared_x", 32'(p1_x), 164);
    chk("cleared_dir", 32'(p1_dir), 4);

    // Walk p2 to x=606 and p1 to y=2, then boost into the field edges
    drive(1, 0, 0, 0, 0); cycle();
    for (int k = 0; k < 199; k++) tick_with(1, 0, (k < 79) ? 4 : 0, 0);
    chk("edge_pre_x", 32'(p2_x), 606);
    chk("edge_pre_y", 32'(p1_y), 2);
    tick_with(1, 1, 4, 1);
    chk("clamp_x", 32'(p2_x), 608);
    chk("clamp_y", 32'(p1_y), 0);

    // SETTING reloads start; PAUSE freezes the count for exactly 2 cycles
    drive(1, 0, 0, 0, 0); cycle();
    chk("reload_x", 32'(p2_x), 448);
    chk("reload_y", 32'(p1_y), 400);
    drive(4, 2, 0, 0, 0); cycle();
    drive(4, 0, 0, 0, 0); cycle();
    drive(5, 0, 0, 0, 0); cycle(); cycle();
    n = 4;
    drive(4, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      n++;
      if (move_pulse) break;
    end
    chk("pause_delay", 32'(n), 6);
    chk("pause_move_y", 32'(p1_y), 402);

    // Carts driven into each other at (400,400) and (434,400)
    drive(1, 0, 0, 0, 0); cycle();
    for (int k = 0; k < 120; k++) tick_with(4, 0, (k < 7) ? 3 : 0, 0);
    chk("meet_p1_x", 32'(p1_x), 400);
    chk("meet_p2_x", 32'(p2_x), 434);
    tick_with(4, 0, 3, 0);
`ifdef CART_COLLISION_EN
    chk("coll_p1_x", 32'(p1_x), 400);
    chk("coll_p2_x", 32'(p2_x), 434);
    chk("coll_pulse", 32'(collide_pulse), 1);
`else
    chk("coll_p1_x", 32'(p1_x), 402);
    chk("coll_p2_x", 32'(p2_x), 432);
    chk("coll_pulse", 32'(collide_pulse), 0);
`endif
    chk("coll_dir2", 32'(p2_dir), 3);

    // Asynchronous reset while a LEFT request is pending
    drive(1, 0, 0, 0, 0); cycle();
    drive(4, 3, 1, 2, 0); cycle();
    drive(4, 0, 0, 0, 0); cycle();
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
    for (int i = 0; i < SD; i++) cycle();
    chk("rst_no_move_x", 32'(p1_x), 160);
    chk("rst_no_move_y", 32'(p2_y), 400);
    chk("rst_tick_pulse", 32'(move_pulse), 1);

    // Randomised play
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) < 14)
        state = 3'd4;
      else
        state = 3'($urandom_range(0, 6));
      p1op = 3'($urandom_range(0, 7));
      p2op = 3'($urandom_range(0, 7));
      p1b  = ($urandom_range(0, 3) == 0);
      p2b  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
